// File: rtl/trap_csr_unit.sv
// rtl/trap_csr_unit.sv - machine-mode trap controller, privilege tracker and M-mode CSR file
module trap_csr_unit #(
   parameter int               XLEN        = 32,
   parameter logic [XLEN-1:0]  RESET_MTVEC = '0,
   parameter logic [1:0]       RESET_PRIV  = 2'b11
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   input  logic            i_exception,
   input  logic            i_mret,
   input  logic [3:0]      i_causeNum,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_csrWrite,
   input  logic [11:0]     i_csrAddr,
   input  logic [XLEN-1:0] i_csrWdata,
   output logic [XLEN-1:0] o_csrRdata,
   output logic [1:0]      o_nowPrivMode,
   output logic            o_redirect,
   output logic [XLEN-1:0] o_redirectPC
);

   localparam logic [1:0]      PRIV_M     = 2'b11;
   localparam logic [1:0]      PRIV_U     = 2'b00;
   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

   typedef enum logic {IDLE, REDIRECT} state_t;

   state_t          state_q, state_d;
   logic            mie_q, mie_d;
   logic            mpie_q, mpie_d;
   logic [1:0]      mpp_q, mpp_d;
   logic [1:0]      priv_q, priv_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;
   logic [3:0]      mcause_q, mcause_d;
   logic            redirect_q, redirect_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

   logic take_exc;
   logic take_mret;
   logic csr_we;

   // Trap/return commit, CSR writes and the redirect FSM; the squashed REDIRECT cycle changes nothing
   always_comb begin
      state_d       = state_q;
      mie_d         = mie_q;
      mpie_d        = mpie_q;
      mpp_d         = mpp_q;
      priv_d        = priv_q;
      mtvec_d       = mtvec_q;
      mepc_d        = mepc_q;
      mscratch_d    = mscratch_q;
      mcause_d      = mcause_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;

      take_exc  = (state_q == IDLE) && i_valid && i_exception;
      take_mret = (state_q == IDLE) && i_valid && i_mret && !i_exception;
      csr_we    = (state_q == IDLE) && i_valid && i_csrWrite && !take_exc && !take_mret;

      if (csr_we) begin
         case (i_csrAddr)
            ADDR_MSTATUS: begin
               mie_d  = i_csrWdata[3];
               mpie_d = i_csrWdata[7];
               // Only M and U exist, so the reserved encodings collapse to U
               mpp_d  = (i_csrWdata[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
            end
            ADDR_MTVEC:    mtvec_d    = i_csrWdata;
            ADDR_MSCRATCH: mscratch_d = i_csrWdata;
            ADDR_MEPC:     mepc_d     = i_csrWdata;
            ADDR_MCAUSE:   mcause_d   = i_csrWdata[3:0];
            default: ;
         endcase
      end

      if (take_exc) begin
         mepc_d        = i_pc;
         // An ecall from M-mode is reported as environment-call-from-M
         mcause_d      = (i_causeNum == 4'd8 && priv_q == PRIV_M) ? 4'd11 : i_causeNum;
         mpie_d        = mie_q;
         mie_d         = 1'b0;
         mpp_d         = priv_q;
         priv_d        = PRIV_M;
         redirect_d    = 1'b1;
         redirect_pc_d = mtvec_q & ALIGN_MASK;
         state_d       = REDIRECT;
      end else if (take_mret) begin
         priv_d        = mpp_q;
         mie_d         = mpie_q;
         mpie_d        = 1'b1;
         mpp_d         = PRIV_U;
         redirect_d    = 1'b1;
         redirect_pc_d = mepc_q & ALIGN_MASK;
         state_d       = REDIRECT;
      end else if (state_q == REDIRECT) begin
         state_d = IDLE;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= IDLE;
         mie_q         <= 1'b0;
         mpie_q        <= 1'b0;
         mpp_q         <= 2'b00;
         priv_q        <= RESET_PRIV;
         mtvec_q       <= RESET_MTVEC & ALIGN_MASK;
         mepc_q        <= '0;
         mscratch_q    <= '0;
         mcause_q      <= 4'd0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         mie_q         <= mie_d;
         mpie_q        <= mpie_d;
         mpp_q         <= mpp_d;
         priv_q        <= priv_d;
         mtvec_q       <= mtvec_d;
         mepc_q        <= mepc_d;
         mscratch_q    <= mscratch_d;
         mcause_q      <= mcause_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   // Combinational CSR read of the current register values; low alignment bits are hidden here
   always_comb begin
      o_csrRdata = '0;
      case (i_csrAddr)
         ADDR_MSTATUS: begin
            o_csrRdata[3]     = mie_q;
            o_csrRdata[7]     = mpie_q;
            o_csrRdata[12:11] = mpp_q;
         end
         ADDR_MTVEC:    o_csrRdata      = mtvec_q & ALIGN_MASK;
         ADDR_MSCRATCH: o_csrRdata      = mscratch_q;
         ADDR_MEPC:     o_csrRdata      = mepc_q & ALIGN_MASK;
         ADDR_MCAUSE:   o_csrRdata[3:0] = mcause_q;
         default: ;
      endcase
   end

   assign o_nowPrivMode = priv_q;
   assign o_redirect    = redirect_q;
   assign o_redirectPC  = redirect_pc_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// tb/tb_trap_csr_unit.sv - directed and randomized checks of trap_csr_unit against a behavioural model
module tb_trap_csr_unit;

   localparam logic [31:0] RST_MTVEC = 32'h0000_1003;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid, i_exception, i_mret, i_csrWrite;
   logic [3:0]  i_causeNum;
   logic [31:0] i_pc, i_csrWdata;
   logic [11:0] i_csrAddr;
   logic [31:0] o_csrRdata;
   logic [1:0]  o_nowPrivMode;
   logic        o_redirect;
   logic [31:0] o_redirectPC;

   int tests = 0;
   int fails = 0;

   trap_csr_unit #(.XLEN(32), .RESET_MTVEC(RST_MTVEC), .RESET_PRIV(2'b11)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_exception(i_exception),
      .i_mret(i_mret), .i_causeNum(i_causeNum), .i_pc(i_pc), .i_csrWrite(i_csrWrite),
      .i_csrAddr(i_csrAddr), .i_csrWdata(i_csrWdata), .o_csrRdata(o_csrRdata),
      .o_nowPrivMode(o_nowPrivMode), .o_redirect(o_redirect), .o_redirectPC(o_redirectPC)
   );

   always #5 i_clk = ~i_clk;

   // Architectural model: CSRs held as read-visible values keyed by address
   logic [31:0] arch [int];
   logic [1:0]  m_priv;
   logic        m_redir;
   logic [31:0] m_redir_pc;

   task automatic model_reset();
      arch.delete();
      arch[12'h300] = 32'h0;
      arch[12'h305] = RST_MTVEC & 32'hFFFF_FFFC;
      arch[12'h340] = 32'h0;
      arch[12'h341] = 32'h0;
      arch[12'h342] = 32'h0;
      m_priv     = 2'b11;
      m_redir    = 1'b0;
      m_redir_pc = 32'h0;
   endtask

   function automatic logic [31:0] model_read(input logic [11:0] a);
      if (arch.exists(int'(a))) return arch[int'(a)];
      return 32'h0;
   endfunction

   function automatic logic [31:0] pack_mstatus(input logic mie, input logic mpie, input logic [1:0] mpp);
      return (32'(mie) << 3) | (32'(mpie) << 7) | (32'(mpp) << 11);
   endfunction

   task automatic model_write(input logic [11:0] a, input logic [31:0] w);
      logic [1:0] mpp;
      case (a)
         12'h300: begin
            mpp = (w[12:11] == 2'b11) ? 2'b11 : 2'b00;
            arch[12'h300] = pack_mstatus(w[3], w[7], mpp);
         end
         12'h305: arch[12'h305] = w & 32'hFFFF_FFFC;
         12'h340: arch[12'h340] = w;
         12'h341: arch[12'h341] = w & 32'hFFFF_FFFC;
         12'h342: arch[12'h342] = {28'h0, w[3:0]};
         default: ;
      endcase
   endtask

   task automatic model_step(input logic v, input logic exc, input logic mret, input logic [3:0] cause,
                             input logic [31:0] pc, input logic we, input logic [11:0] a, input logic [31:0] w);
      logic        live, mie, mpie;
      logic [1:0]  mpp;
      live = v && !m_redir;
      mie  = arch[12'h300][3];
      mpie = arch[12'h300][7];
      mpp  = arch[12'h300][12:11];
      if (live && exc) begin
         m_redir_pc    = arch[12'h305];
         arch[12'h341] = pc & 32'hFFFF_FFFC;
         arch[12'h342] = (cause == 4'd8 && m_priv == 2'b11) ? 32'd11 : {28'h0, cause};
         arch[12'h300] = pack_mstatus(1'b0, mie, m_priv);
         m_priv        = 2'b11;
         m_redir       = 1'b1;
      end else if (live && mret) begin
         m_redir_pc    = arch[12'h341];
         m_priv        = mpp;
         arch[12'h300] = pack_mstatus(mpie, 1'b1, 2'b00);
         m_redir       = 1'b1;
      end else begin
         if (live && we) model_write(a, w);
         m_redir = 1'b0;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [11:0] addrs [6];
      addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0};
      check({tag, "_redirect"}, 32'(o_redirect), 32'(m_redir));
      check({tag, "_redirect_pc"}, o_redirectPC, m_redir_pc);
      check({tag, "_priv"}, 32'(o_nowPrivMode), 32'(m_priv));
      foreach (addrs[k]) begin
         i_csrAddr = addrs[k];
         #1;
         check($sformatf("%s_csr%h", tag, addrs[k]), o_csrRdata, model_read(addrs[k]));
      end
   endtask

   task automatic cycle(input logic v, input logic exc, input logic mret, input logic [3:0] cause,
                        input logic [31:0] pc, input logic we, input logic [11:0] a, input logic [31:0] w);
      i_valid = v; i_exception = exc; i_mret = mret; i_causeNum = cause; i_pc = pc;
      i_csrWrite = we; i_csrAddr = a; i_csrWdata = w;
      model_step(v, exc, mret, cause, pc, we, a, w);
      @(posedge i_clk);
      #1;
   endtask

   task automatic read_csr(input logic [11:0] a, output logic [31:0] d);
      i_csrAddr = a;
      #1;
      d = o_csrRdata;
   endtask

   initial begin
      logic [31:0] rd;
      logic [11:0] addr_pool [7];
      addr_pool = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h301, 12'h343};

      i_rst_n = 1'b0;
      i_valid = 0; i_exception = 0; i_mret = 0; i_causeNum = 0; i_pc = 0;
      i_csrWrite = 0; i_csrAddr = 0; i_csrWdata = 0;
      model_reset();
      repeat (2) @(posedge i_clk);
      #1;
      // 1: reset state
      read_csr(12'h305, rd);
      check("reset_mtvec", rd, 32'h0000_1000);
      check_all("reset");
      i_rst_n = 1'b1;

      // 2: drop to U with MIE=1, mtvec=0x100, then ecall from U
      cycle(1, 0, 0, 0, 0, 1, 12'h305, 32'h0000_0100); check_all("s2_mtvec");
      cycle(1, 0, 0, 0, 0, 1, 12'h300, 32'h0000_0080); check_all("s2_mstatus");
      cycle(1, 0, 0, 0, 0, 1, 12'h341, 32'h0000_2000); check_all("s2_mepc");
      cycle(1, 0, 1, 0, 0, 0, 12'h0,   32'h0);         check_all("s2_mret");
      cycle(0, 0, 0, 0, 0, 0, 12'h0,   32'h0);         check_all("s2_idle");
      check("s2_priv_u", 32'(o_nowPrivMode), 32'h0);
      cycle(1, 1, 0, 4'd8, 32'h2004, 0, 12'h0, 32'h0); check_all("s2_exc");
      check("s2_redirect_pc", o_redirectPC, 32'h100);
      read_csr(12'h342, rd); check("s2_mcause", rd, 32'd8);
      read_csr(12'h300, rd); check("s2_mstatus", rd, 32'h0000_0080);
      cycle(0, 0, 0, 0, 0, 0, 12'h0, 32'h0); check_all("s2_after");

      // 3: ecall from M
      cycle(1, 1, 0, 4'd8, 32'h3000, 0, 12'h0, 32'h0); check_all("s3_exc");
      read_csr(12'h342, rd); check("s3_mcause", rd, 32'd11);
      read_csr(12'h300, rd); check("s3_mpp", 32'(rd[12:11]), 32'h3);
      cycle(0, 0, 0, 0, 0, 0, 12'h0, 32'h0); check_all("s3_after");

      // 4: mret to U at 0x2008
      cycle(1, 0, 0, 0, 0, 1, 12'h341, 32'h0000_2008); check_all("s4_mepc");
      cycle(1, 0, 0, 0, 0, 1, 12'h300, 32'h0000_0080); check_all("s4_mstatus");
      cycle(1, 0, 1, 0, 0, 0, 12'h0, 32'h0);           check_all("s4_mret");
      check("s4_redirect_pc", o_redirectPC, 32'h2008);
      read_csr(12'h300, rd); check("s4_mstatus_after", rd, 32'h0000_0088);
      cycle(0, 0, 0, 0, 0, 0, 12'h0, 32'h0); check_all("s4_after");

      // 5: exception beats CSR write; exception during REDIRECT is ignored
      cycle(1, 1, 0, 4'd2, 32'h4000, 1, 12'h340, 32'h0000_DEAD); check_all("s5_exc_we");
      read_csr(12'h340, rd); check("s5_mscratch", rd, 32'h0);
      cycle(1, 1, 0, 4'd5, 32'h5000, 0, 12'h0, 32'h0); check_all("s5_squashed");
      read_csr(12'h341, rd); check("s5_mepc", rd, 32'h4000);

      // 6: async reset during redirect; MPP=01 write reads back 00
      cycle(1, 1, 0, 4'd3, 32'h6000, 0, 12'h0, 32'h0); check_all("s6_exc");
      i_rst_n = 1'b0;
      #1;
      check("s6_redirect_drop", 32'(o_redirect), 32'h0);
      model_reset();
      check_all("s6_reset");
      i_rst_n = 1'b1;
      cycle(1, 0, 0, 0, 0, 1, 12'h300, 32'h0000_0800); check_all("s6_mpp01");
      read_csr(12'h300, rd); check("s6_mpp_reads_00", 32'(rd[12:11]), 32'h0);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic v, exc, mret, we;
         v    = ($urandom_range(0, 7) != 0);
         exc  = ($urandom_range(0, 5) == 0);
         mret = ($urandom_range(0, 5) == 0);
         we   = ($urandom_range(0, 1) == 1);
         cycle(v, exc, mret, 4'($urandom_range(0, 15)), $urandom, we,
               addr_pool[$urandom_range(0, 6)], $urandom);
         check_all($sformatf("rnd%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
